mmm_mod_pow_final_reduce: RTL and testbench
===========================================

// Module: mmm_mod_pow_final_reduce
// PURPOSE
//   Output stage directly downstream of mmm_mod_pow. Takes the exponentiator's
//   partially reduced result (width WIDTH+4, range [0, 8p)) and reduces it to the
//   canonical residue [0, p). Uses three pipelined conditional subtractions: 4p, 2p, p.
//   Results are buffered in a FWFT FIFO behind a valid/ready handshake, so the
//   consumer can apply backpressure without losing any result.
// PARAMETERS
//   WIDTH  256  modulus / canonical result width (bits)
//   DEPTH  4    output FIFO depth (entries), power of 2, >= 4
// PORTS
//   i_clk    in   1          system clock, all logic on rising edge
//   i_rst    in   1          synchronous reset, active-high
//   i_vld    in   1          input result valid
//   o_rdy    out  1          stage can accept; transfer when i_vld & o_rdy
//   i_res    in   WIDTH+4    partially reduced result from mmm_mod_pow
//   i_p      in   WIDTH      modulus for this transaction (latched with i_res)
//   o_vld    out  1          FIFO head valid
//   i_rdy    in   1          consumer ready; pop when o_vld & i_rdy
//   o_res    out  WIDTH      canonical residue, in [0, p)
//   o_err    out  1          head entry had i_res >= 8p (qualified by o_vld)
// BEHAVIOUR
//   - Reset (i_rst=1 at a rising edge):
//     - o_vld=0, o_err=0, o_res=0, o_rdy=0 during reset.
//     - Pipeline valids cleared, FIFO pointers/count zeroed; in-flight data discarded.
//     - o_rdy=1 from the first cycle after i_rst deasserts.
//   - Pipeline. All arithmetic is WIDTH+4 bits unsigned; p is zero-extended.
//     - S1: x1 = (x >= 4p) ? x-4p : x. Registered with p and valid.
//     - S2: x2 = (x1 >= 2p) ? x1-2p : x1. Registered.
//     - S3: x3 = (x2 >= p) ? x2-p : x2. Written into the FIFO along with
//       err = (x3 >= p). x3[WIDTH-1:0] is stored either way.
//     - Compares use the subtraction borrow; no separate comparator.
//   - Latency:
//     - An input accepted at edge k is written to the FIFO at edge k+2.
//     - If the FIFO was empty, o_vld=1 with that data in the cycle after edge k+2,
//       i.e. 3 cycles after acceptance.
//   - Pipeline advances every cycle; it never stalls. Flow control is credit-based:
//     - occ = FIFO count + number of valid S1/S2 stages.
//     - o_rdy = (occ < DEPTH). The FIFO therefore never overflows.
//     - o_rdy is registered-input combinational: a function of state only,
//       never of i_vld or i_rdy.
//   - FIFO: first-word fall-through.
//     - o_res/o_err driven from the head entry.
//     - Read/write pointers wrap modulo DEPTH.
//     - Push and pop in the same cycle: count unchanged. Legal when full or empty.
//     - Empty + push: o_vld rises next cycle. Pop of last entry: o_vld falls next cycle.
//   - Order is strictly preserved; one result out per result in; no drops, no duplicates.
//   - i_vld while o_rdy=0: ignored, not accepted. Upstream holds i_vld/i_res.
//   - o_res when o_vld=0: holds last head value (don't-care for the checker).
// TESTING
//   Use p = FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F, i_rdy=1.
//   1. i_res=p+5 -> o_res=5, o_err=0, o_vld 3 cycles after acceptance.
//      i_res=0 -> o_res=0. i_res=p-1 -> o_res=p-1.
//   2. i_res=7p+1 -> 1. i_res=4p -> 0. i_res=8p-1 -> p-1. All with o_err=0.
//      i_res=8p -> o_err=1.
//   3. Back-to-back stream of 20 random x in [0,8p), i_vld=1 every cycle ->
//      20 outputs equal to x mod p, in order, one per cycle, o_rdy held high.
//   4. i_rdy=0, i_vld=1 continuously:
//      - exactly DEPTH (4) transfers accepted, then o_rdy=0; FIFO holds 4 entries.
//      - Then i_rdy=1: 4 results in order.
//      - o_rdy returns to 1 within 1 cycle of the first pop.
//   5. FIFO full with i_rdy=1 and a new transfer offered in the same cycle ->
//      no loss, count stays DEPTH. Run long enough to exercise pointer wrap (>=3*DEPTH).
//   6. Assert i_rst for 1 cycle with 2 items in flight and 2 in the FIFO ->
//      o_vld=0 next cycle, no stale results ever emitted.
//      A subsequent i_res=p+9 yields exactly one output, 9.

Source files
------------

// File: rtl/mmm_mod_pow_final_reduce.sv
// Final reduction of a modular exponentiation result from [0, 8p) to [0, p).
// Three pipelined conditional subtractions (4p, 2p, p) feed a first-word fall-through output FIFO.
module mmm_mod_pow_final_reduce #(
  parameter int WIDTH = 256,
  parameter int DEPTH = 4
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_vld,
  output logic               o_rdy,
  input  logic [WIDTH+3:0]   i_res,
  input  logic [WIDTH-1:0]   i_p,
  output logic               o_vld,
  input  logic               i_rdy,
  output logic [WIDTH-1:0]   o_res,
  output logic               o_err
);

  localparam int XW = WIDTH + 4;
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic             v1, v2;
  logic [XW-1:0]    x1, x2;
  logic [WIDTH-1:0] p1, p2;

  logic [WIDTH-1:0] mem_res [DEPTH];
  logic             mem_err [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count;

  // The borrow out of each subtraction doubles as the "x < k*p" compare.
  logic [XW:0]   d4, d2, d1, de;
  logic [XW-1:0] s1, s2, x3;
  logic          err3;

  assign d4   = {1'b0, i_res} - {1'b0, 2'b00, i_p, 2'b00};
  assign s1   = d4[XW] ? i_res : d4[XW-1:0];
  assign d2   = {1'b0, x1} - {1'b0, 3'b000, p1, 1'b0};
  assign s2   = d2[XW] ? x1 : d2[XW-1:0];
  assign d1   = {1'b0, x2} - {1'b0, 4'b0000, p2};
  assign x3   = d1[XW] ? x2 : d1[XW-1:0];
  assign de   = {1'b0, x3} - {1'b0, 4'b0000, p2};
  assign err3 = ~de[XW];

  logic unused_bits;
  assign unused_bits = ^{de[XW-1:0], x3[XW-1:WIDTH]};

  logic          accept, push, pop;
  logic [CW:0]   occ;

  // Credit count: every valid pipeline stage reserves one FIFO slot.
  assign occ    = {1'b0, count} + (CW+1)'(v1) + (CW+1)'(v2);
  assign o_rdy  = ~i_rst & (occ < (CW+1)'(DEPTH));
  assign accept = i_vld & o_rdy;
  assign push   = v2;
  assign o_vld  = ~i_rst & (count != '0);
  assign pop    = o_vld & i_rdy;
  assign o_res  = i_rst ? '0 : mem_res[rd_ptr];
  assign o_err  = o_vld & mem_err[rd_ptr];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      v1     <= 1'b0;
      v2     <= 1'b0;
      x1     <= '0;
      x2     <= '0;
      p1     <= '0;
      p2     <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_res[i] <= '0;
        mem_err[i] <= 1'b0;
      end
    end else begin
      v1 <= accept;
      v2 <= v1;
      if (accept) begin
        x1 <= s1;
        p1 <= i_p;
      end
      if (v1) begin
        x2 <= s2;
        p2 <= p1;
      end
      if (push) begin
        mem_res[wr_ptr] <= x3[WIDTH-1:0];
        mem_err[wr_ptr] <= err3;
        wr_ptr          <= wr_ptr + 1'b1;
      end
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_mmm_mod_pow_final_reduce.sv
// Randomized bench for mmm_mod_pow_final_reduce: a queue of expected residues
// (x mod p computed directly) is filled on every accepted input and drained on every pop.
module tb_mmm_mod_pow_final_reduce;

  localparam int WIDTH = 256;
  localparam int DEPTH = 4;
  localparam logic [WIDTH-1:0] P =
    256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;

  logic               clk = 1'b0;
  logic               rst;
  logic               i_vld;
  logic               o_rdy;
  logic [WIDTH+3:0]   i_res;
  logic [WIDTH-1:0]   i_p;
  logic               o_vld;
  logic               i_rdy;
  logic [WIDTH-1:0]   o_res;
  logic               o_err;

  mmm_mod_pow_final_reduce #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .i_clk(clk), .i_rst(rst), .i_vld(i_vld), .o_rdy(o_rdy), .i_res(i_res),
    .i_p(i_p), .o_vld(o_vld), .i_rdy(i_rdy), .o_res(o_res), .o_err(o_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] res;
    logic             err;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_pass = 0;
  int   n_acc  = 0;
  int   n_out  = 0;

  logic [287:0] p_ext, p8;

  task automatic check(input string tag, input logic [287:0] obs, input logic [287:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic exp_t model(input logic [WIDTH+3:0] x);
    exp_t e;
    logic [287:0] xe;
    xe = {28'b0, x};
    e.err = (xe >= p8);
    e.res = WIDTH'(xe % p_ext);
    return e;
  endfunction

  function automatic logic [WIDTH+3:0] rand_x();
    logic [287:0] r;
    for (int i = 0; i < 9; i++) r[i*32 +: 32] = $urandom;
    return (WIDTH+4)'(r % p8);
  endfunction

  // Scoreboard: inputs are stable from posedge+1 until the next posedge, so the
  // negedge view matches what the DUT samples.
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
    end else begin
      if (o_vld && i_rdy) begin
        if (q.size() == 0) begin
          check("spurious_out", 1, 0);
        end else begin
          exp_t e;
          e = q.pop_front();
          check("err", o_err, e.err);
          if (!e.err) check("res", o_res, e.res);
        end
        n_out++;
      end
      if (i_vld && o_rdy) begin
        q.push_back(model(i_res));
        n_acc++;
      end
    end
  end

  task automatic send(input logic [WIDTH+3:0] x);
    bit done = 0;
    i_vld = 1'b1;
    i_res = x;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (o_rdy) done = 1;
      @(posedge clk); #1;
    end
    if (!done) check("send_timeout", 0, 1);
    i_vld = 1'b0;
  endtask

  task automatic drain();
    bit done = 0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (q.size() == 0 && !o_vld) done = 1;
    end
    if (!done) check("drain_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, base_acc, base_out, cnt;
    bit acc;
    p_ext = {32'b0, P};
    p8    = p_ext << 3;
    rst = 1'b1; i_vld = 1'b0; i_res = '0; i_p = P; i_rdy = 1'b1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_vld", o_vld, 0);
    check("rst_rdy", o_rdy, 0);
    check("rst_res", o_res, 0);
    check("rst_err", o_err, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_rdy", o_rdy, 1);
    @(posedge clk); #1;

    // Directed values, with latency on the first one
    send({4'b0, P} + 5);
    n = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n++;
      if (o_vld) break;
    end
    check("latency", n, 3);
    drain();
    send('0);
    send({4'b0, P} - 1);
    send(WIDTH'(7) * {4'b0, P} + 1);
    send({2'b0, P, 2'b0});
    send(p8[WIDTH+3:0] - 1);
    send(p8[WIDTH+3:0]);
    drain();

    // Back-to-back random stream
    base_out = n_out;
    for (int i = 0; i < 20; i++) begin
      i_vld = 1'b1;
      i_res = rand_x();
      @(negedge clk);
      check("stream_rdy", o_rdy, 1);
      @(posedge clk); #1;
    end
    i_vld = 1'b0;
    drain();
    check("stream_count", n_out - base_out, 20);

    // Backpressure fill: exactly DEPTH accepted
    i_rdy = 1'b0;
    base_acc = n_acc;
    base_out = n_out;
    i_vld = 1'b1;
    i_res = rand_x();
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      acc = o_rdy;
      @(posedge clk); #1;
      if (acc) i_res = rand_x();
    end
    i_vld = 1'b0;
    check("fill_acc", n_acc - base_acc, DEPTH);
    @(negedge clk);
    check("full_rdy", o_rdy, 0);
    check("full_vld", o_vld, 1);
    @(posedge clk); #1;
    i_rdy = 1'b1;
    @(negedge clk);
    check("pre_pop_rdy", o_rdy, 0);
    @(negedge clk);
    check("rdy_after_pop", o_rdy, 1);
    drain();
    check("fill_out", n_out - base_out, DEPTH);

    // Random valid/ready, starting from a full FIFO, long enough to wrap
    base_acc = n_acc;
    base_out = n_out;
    i_rdy = 1'b0;
    i_vld = 1'b1;
    i_res = rand_x();
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      acc = i_vld && o_rdy;
      @(posedge clk); #1;
      if (!i_vld || acc) begin
        i_vld = ($urandom % 4) != 0;
        i_res = rand_x();
      end
      i_rdy = (i < 10) ? 1'b0 : (($urandom % 3) != 0);
    end
    i_vld = 1'b0;
    i_rdy = 1'b1;
    drain();
    check("random_count", n_out - base_out, n_acc - base_acc);

    // Reset with 2 in flight and 2 in the FIFO
    i_rdy = 1'b0;
    i_vld = 1'b1;
    i_res = rand_x();
    cnt = 0;
    for (int i = 0; i < 20 && cnt < 4; i++) begin
      @(negedge clk);
      if (o_rdy) cnt++;
      @(posedge clk); #1;
      i_res = rand_x();
    end
    check("rst_fill", cnt, 4);
    i_vld = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_flush_vld", o_vld, 0);
    i_rdy = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("rst_no_stale", o_vld, 0);
    end
    @(posedge clk); #1;
    base_out = n_out;
    send({4'b0, P} + 9);
    n = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (o_vld) begin
        n++;
        if (n == 1) check("rst_after_res", o_res, 9);
      end
    end
    check("rst_after_count", n_out - base_out, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
